fp_div_sqrt_seq: RTL
====================

FP_DIV_SQRT_SEQ -- requirements
Module: fp_div_sqrt_seq

Interface
- REQ-001 SHALL have parameter DIV_ITERS, default 5: ITER cycles for fdiv (legal range 1..31).
- REQ-002 SHALL have parameter SQRT_ITERS, default 7: ITER cycles for fsqrt (legal range 1..31).
- REQ-003 clk  input  1  sole clock; all state updates on rising edge.
- REQ-004 clrn  input  1  asynchronous, active-low reset.
- REQ-005 start  input  1  issue pulse for fdiv/fsqrt from ID; qualified by pipeline write-enable.
- REQ-006 sqrt  input  1  op select, sampled with start: 0 = fdiv, 1 = fsqrt.
- REQ-007 flush  input  1  cancel in-flight operation.
- REQ-008 wb_ack  input  1  pipeline has taken the result this cycle.
- REQ-009 load  output  1  datapath latches operands.
- REQ-010 iter_en  output  1  datapath performs one iteration step.
- REQ-011 norm  output  1  datapath normalises/rounds.
- REQ-012 sel_sqrt  output  1  registered op select driven to datapath.
- REQ-013 count  output  5  remaining ITER cycles.
- REQ-014 result_valid  output  1  result available for writeback.
- REQ-015 stall_div_sqrt  output  1  freezes PC/IF/ID (feeds the wpcir stall term).
- REQ-016 busy  output  1  high in every state except IDLE.
- REQ-017 proto_err  output  1  sticky illegal-issue flag.

Function
- REQ-018 SHALL implement states IDLE, LOAD, ITER, NORM, DONE.
- REQ-019 IDLE & start: SHALL go to LOAD, capture sqrt into sel_sqrt.
- REQ-020 LOAD: SHALL assert load for one cycle, set count = (sel_sqrt ? SQRT_ITERS : DIV_ITERS) - 1, then go to ITER.
- REQ-021 ITER: SHALL assert iter_en each cycle and decrement count; at count == 0 SHALL go to NORM.
- REQ-022 NORM: SHALL assert norm for one cycle, then go to DONE.
- REQ-023 DONE: SHALL hold result_valid = 1 until wb_ack, then go to IDLE.
- REQ-024 DONE with wb_ack & start in the same cycle: SHALL go directly to LOAD, capturing the new sqrt (back-to-back issue).
- REQ-025 Latency: start at cycle 0 SHALL give result_valid first high at cycle N+3, where N = iteration count.
- REQ-026 stall_div_sqrt SHALL be high in LOAD, ITER and NORM, and low in IDLE and DONE.
- REQ-027 load, iter_en, norm and result_valid SHALL be mutually exclusive.
- REQ-028 start in LOAD, ITER or NORM, or start in DONE without wb_ack: SHALL be ignored and SHALL set proto_err until reset.
- REQ-029 flush: SHALL force IDLE on the next edge from any state and SHALL take priority over start and wb_ack; count keeps its value, result_valid drops.
- REQ-030 wb_ack outside DONE SHALL have no effect.
- REQ-031 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs.

Reset
- REQ-032 clrn low SHALL immediately force IDLE, count = 0, sel_sqrt = 0, proto_err = 0, and all strobes, busy and stall_div_sqrt to 0.
- REQ-033 Reset asserted mid-operation SHALL discard the operation; no result_valid follows release.
- REQ-034 After clrn rises, the first rising edge SHALL accept start.

Structure
- REQ-035 State encoding and FP op codes (fadd 000, fsub 001, fmul 01x, fdiv 10x, fsqrt 11x) SHALL live in the shared FPU constants file.
- REQ-036 The block SHALL be single-level: one FSM plus the down-counter, with no sub-modules.
- REQ-037 The ID-stage controller SHALL drive start from fc[2] & wf and SHALL consume stall_div_sqrt.

Verification
- REQ-038 fdiv: start = 1, sqrt = 0 at cycle 0 -> load at cycle 1, iter_en at cycles 2-6, norm at cycle 7, result_valid at cycle 8; stall_div_sqrt high at cycles 1-7.
- REQ-039 fsqrt: start = 1, sqrt = 1 -> iter_en for 7 cycles, result_valid at cycle 10, sel_sqrt = 1 throughout.
- REQ-040 Back-to-back: wb_ack & start (sqrt = 1) in DONE -> LOAD on the next cycle, no IDLE cycle, count = 6.
- REQ-041 flush at third ITER cycle -> IDLE on the next cycle, busy = 0, and no result_valid within 20 cycles.
- REQ-042 clrn pulsed low mid-ITER -> all outputs 0 asynchronously; a fresh start afterwards completes with normal latency.
- REQ-043 start during ITER -> proto_err = 1 and stays 1; the current operation completes with unchanged timing.

Source files
------------

// File: rtl/fp_div_sqrt_seq_pkg.sv
// Shared FPU constants: divide/sqrt sequencer state encoding, FP op codes
// and small helpers used by the ID-stage controller and the sequencer.
package fp_div_sqrt_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_NORM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // fc[2] marks the long-latency ops; fc[1] picks sqrt over div.
  localparam logic [2:0] FOP_FADD  = 3'b000;
  localparam logic [2:0] FOP_FSUB  = 3'b001;
  localparam logic [2:0] FOP_FMUL  = 3'b010;
  localparam logic [2:0] FOP_FDIV  = 3'b100;
  localparam logic [2:0] FOP_FSQRT = 3'b110;

  localparam int CNT_W = 5;

  function automatic logic is_div_sqrt(input logic [2:0] fc);
    return fc[2];
  endfunction

  function automatic logic [CNT_W-1:0] iter_preset(input logic sel, input int div_iters,
                                                   input int sqrt_iters);
    int n;
    n = sel ? sqrt_iters : div_iters;
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/fp_div_sqrt_seq.sv
// Sequencer for the multi-cycle fdiv/fsqrt datapath: issues load, iteration and
// normalise strobes, stalls the front end and holds the result until writeback.
//
//   state | meaning
//   IDLE  | waiting for an issue pulse
//   LOAD  | datapath latches operands, iteration count preset
//   ITER  | one iteration step per cycle until count reaches zero
//   NORM  | datapath normalises/rounds
//   DONE  | result held valid until the pipeline acknowledges it
module fp_div_sqrt_seq
  import fp_div_sqrt_seq_pkg::*;
#(
  parameter int DIV_ITERS  = 5,
  parameter int SQRT_ITERS = 7
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             sqrt,
  input  logic             flush,
  input  logic             wb_ack,
  output logic             load,
  output logic             iter_en,
  output logic             norm,
  output logic             sel_sqrt,
  output logic [CNT_W-1:0] count,
  output logic             result_valid,
  output logic             stall_div_sqrt,
  output logic             busy,
  output logic             proto_err
);

  state_t state;
  logic   illegal_start;

  // A start is only legal in IDLE, or in DONE when it coincides with the ack.
  always_comb begin
    illegal_start = 1'b0;
    if (start) begin
      case (state)
        ST_LOAD, ST_ITER, ST_NORM: illegal_start = 1'b1;
        ST_DONE:                   illegal_start = !wb_ack;
        default:                   illegal_start = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= ST_IDLE;
      count     <= '0;
      sel_sqrt  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (illegal_start) proto_err <= 1'b1;
      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state    <= ST_LOAD;
              sel_sqrt <= sqrt;
            end
          end
          ST_LOAD: begin
            count <= iter_preset(sel_sqrt, DIV_ITERS, SQRT_ITERS);
            state <= ST_ITER;
          end
          ST_ITER: begin
            if (count == '0) state <= ST_NORM;
            else             count <= count - 1'b1;
          end
          ST_NORM: state <= ST_DONE;
          ST_DONE: begin
            if (wb_ack) begin
              if (start) begin
                state    <= ST_LOAD;
                sel_sqrt <= sqrt;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Strobes are pure state decodes, so no input reaches an output combinationally.
  assign load           = (state == ST_LOAD);
  assign iter_en        = (state == ST_ITER);
  assign norm           = (state == ST_NORM);
  assign result_valid   = (state == ST_DONE);
  assign stall_div_sqrt = load | iter_en | norm;
  assign busy           = (state != ST_IDLE);

endmodule
